// File: rtl/data_checker.sv
// AXI-Stream sink that checks the data_generator byte-ramp pattern and packet framing.
// Optional build macro DATA_CHECKER_RESYNC_EN: realign the expected count to the received byte on a data error.
module data_checker #(
    parameter int DW    = 512,
    parameter int ERR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [63:0]       packet_count,
    input  logic [7:0]        packet_length,
    input  logic              start,
    input  logic [DW-1:0]     AXIS_RX_TDATA,
    input  logic [DW/8-1:0]   AXIS_RX_TKEEP,
    input  logic              AXIS_RX_TVALID,
    input  logic              AXIS_RX_TLAST,
    output logic              AXIS_RX_TREADY,
    output logic              busy,
    output logic              done,
    output logic [63:0]       packets_rcvd,
    output logic [63:0]       beats_rcvd,
    output logic [ERR_W-1:0]  data_errors,
    output logic [ERR_W-1:0]  length_errors,
    output logic [15:0]       stray_beats,
    output logic [63:0]       first_err_beat
);
    localparam int KW = DW / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t      state_r, state_s;
    logic [63:0] count_r, exp_cnt_r, exp_next_s;
    logic [7:0]  pl_r, cyc_idx_r;
    logic        start_pend_r, restart_r, len_flag_r, err_seen_r;
    logic        beat_s, start_act_s, data_err_s, last_pkt_s;

    // Beat qualification, pattern comparison and next expected count
    always_comb begin
        beat_s      = AXIS_RX_TVALID & AXIS_RX_TREADY;
        start_act_s = restart_r | (start & (state_r != RUN));
        last_pkt_s  = ((packets_rcvd + 64'd1) == count_r);
        data_err_s  = (AXIS_RX_TKEEP != {KW{1'b1}});
        for (int i = 0; i < KW; i++) begin
            if (AXIS_RX_TDATA[8*i +: 8] != exp_cnt_r[7:0]) begin
                data_err_s = 1'b1;
            end else begin
                data_err_s = data_err_s;
            end
        end
`ifdef DATA_CHECKER_RESYNC_EN
        exp_next_s = data_err_s ? ({exp_cnt_r[63:8], AXIS_RX_TDATA[7:0]} + 64'd1)
                                : (exp_cnt_r + 64'd1);
`else
        exp_next_s = exp_cnt_r + 64'd1;
`endif
    end

    // Next-state logic; a deferred restart re-arms from whichever state the run ended in
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_act_s) begin
                    state_s = (packet_count != 64'd0) ? RUN : DONE;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (start_act_s) begin
                    state_s = (packet_count != 64'd0) ? RUN : DONE;
                end else if (beat_s && AXIS_RX_TLAST && last_pkt_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, configuration latch and all status counters
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= IDLE;
            AXIS_RX_TREADY <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            packets_rcvd   <= 64'd0;
            beats_rcvd     <= 64'd0;
            data_errors    <= {ERR_W{1'b0}};
            length_errors  <= {ERR_W{1'b0}};
            stray_beats    <= 16'd0;
            first_err_beat <= {64{1'b1}};
            count_r        <= 64'd0;
            pl_r           <= 8'd4;
            exp_cnt_r      <= 64'd0;
            cyc_idx_r      <= 8'd1;
            start_pend_r   <= 1'b0;
            restart_r      <= 1'b0;
            len_flag_r     <= 1'b0;
            err_seen_r     <= 1'b0;
        end else begin
            AXIS_RX_TREADY <= 1'b1;
            state_r        <= state_s;
            busy           <= (state_s == RUN);
            if (start_act_s) begin
                count_r        <= packet_count;
                pl_r           <= (packet_length == 8'd0) ? 8'd4 : packet_length;
                packets_rcvd   <= 64'd0;
                beats_rcvd     <= 64'd0;
                data_errors    <= {ERR_W{1'b0}};
                length_errors  <= {ERR_W{1'b0}};
                stray_beats    <= 16'd0;
                first_err_beat <= {64{1'b1}};
                exp_cnt_r      <= 64'd0;
                cyc_idx_r      <= 8'd1;
                start_pend_r   <= 1'b0;
                restart_r      <= 1'b0;
                len_flag_r     <= 1'b0;
                err_seen_r     <= 1'b0;
                done           <= (packet_count == 64'd0);
            end else if (state_r == RUN) begin
                if (start) begin
                    start_pend_r <= 1'b1;
                end
                if (beat_s) begin
                    beats_rcvd <= beats_rcvd + 64'd1;
                    exp_cnt_r  <= exp_next_s;
                    if (data_err_s) begin
                        if (data_errors != {ERR_W{1'b1}}) begin
                            data_errors <= data_errors + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                        if (!err_seen_r) begin
                            first_err_beat <= beats_rcvd;
                            err_seen_r     <= 1'b1;
                        end
                    end
                    if (AXIS_RX_TLAST) begin
                        if ((cyc_idx_r != pl_r) && (length_errors != {ERR_W{1'b1}})) begin
                            length_errors <= length_errors + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                        cyc_idx_r    <= 8'd1;
                        len_flag_r   <= 1'b0;
                        packets_rcvd <= packets_rcvd + 64'd1;
                        if (last_pkt_s) begin
                            done <= 1'b1;
                        end
                        // Only a start seen before this TLAST re-arms here
                        if (start_pend_r) begin
                            restart_r    <= 1'b1;
                            start_pend_r <= 1'b0;
                        end
                    end else begin
                        if ((cyc_idx_r == pl_r) && !len_flag_r) begin
                            len_flag_r <= 1'b1;
                            if (length_errors != {ERR_W{1'b1}}) begin
                                length_errors <= length_errors + {{(ERR_W-1){1'b0}}, 1'b1};
                            end
                        end
                        if (cyc_idx_r != 8'd255) begin
                            cyc_idx_r <= cyc_idx_r + 8'd1;
                        end
                    end
                end
            end else begin
                if (beat_s && (stray_beats != 16'hFFFF)) begin
                    stray_beats <= stray_beats + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_checker.sv
// Directed self-checking bench for data_checker: framing, pattern errors, restart and reset.
module tb_data_checker;
    localparam int DW    = 512;
    localparam int ERR_W = 32;
    localparam int KW    = DW / 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic [63:0]       packet_count;
    logic [7:0]        packet_length;
    logic              start;
    logic [DW-1:0]     AXIS_RX_TDATA;
    logic [KW-1:0]     AXIS_RX_TKEEP;
    logic              AXIS_RX_TVALID;
    logic              AXIS_RX_TLAST;
    logic              AXIS_RX_TREADY;
    logic              busy, done;
    logic [63:0]       packets_rcvd, beats_rcvd, first_err_beat;
    logic [ERR_W-1:0]  data_errors, length_errors;
    logic [15:0]       stray_beats;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_checker #(.DW(DW), .ERR_W(ERR_W)) dut (
        .clk(clk), .resetn(resetn), .packet_count(packet_count), .packet_length(packet_length),
        .start(start), .AXIS_RX_TDATA(AXIS_RX_TDATA), .AXIS_RX_TKEEP(AXIS_RX_TKEEP),
        .AXIS_RX_TVALID(AXIS_RX_TVALID), .AXIS_RX_TLAST(AXIS_RX_TLAST),
        .AXIS_RX_TREADY(AXIS_RX_TREADY), .busy(busy), .done(done),
        .packets_rcvd(packets_rcvd), .beats_rcvd(beats_rcvd), .data_errors(data_errors),
        .length_errors(length_errors), .stray_beats(stray_beats), .first_err_beat(first_err_beat)
    );

    task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last);
        @(negedge clk);
        AXIS_RX_TDATA = d; AXIS_RX_TKEEP = k; AXIS_RX_TVALID = 1'b1; AXIS_RX_TLAST = last;
    endtask

    task automatic beat(input logic [7:0] v, input logic last);
        drive({KW{v}}, {KW{1'b1}}, last);
    endtask

    task automatic idle();
        @(negedge clk);
        AXIS_RX_TVALID = 1'b0; AXIS_RX_TLAST = 1'b0;
    endtask

    task automatic pulse_start(input logic [63:0] cnt, input logic [7:0] len);
        @(negedge clk);
        AXIS_RX_TVALID = 1'b0; AXIS_RX_TLAST = 1'b0;
        packet_count = cnt; packet_length = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_run(input int base, input int npk, input int len);
        for (int i = 0; i < npk * len; i++) begin
            beat(8'(base + i), (i % len) == (len - 1));
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({AXIS_RX_TREADY, busy, done} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b exp 000", {AXIS_RX_TREADY, busy, done});
        end
        checks++;
        if ({packets_rcvd, beats_rcvd, data_errors, length_errors, stray_beats} !== {64'd0, 64'd0, 32'd0, 32'd0, 16'd0}) begin
            errors++; $display("FAIL reset_counters got %h exp 0", {packets_rcvd, beats_rcvd, data_errors, length_errors, stray_beats});
        end
        checks++;
        if (first_err_beat !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL reset_first_err got %h exp ffffffffffffffff", first_err_beat);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (AXIS_RX_TREADY !== 1'b1) begin
            errors++; $display("FAIL tready_after_reset got %b exp 1", AXIS_RX_TREADY);
        end
    endtask

    task automatic test_clean();
        pulse_start(64'd3, 8'd4);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++; $display("FAIL clean_busy got %b exp 10", {busy, done});
        end
        send_run(0, 3, 4);
        idle();
        checks++;
        if ({packets_rcvd, beats_rcvd} !== {64'd3, 64'd12}) begin
            errors++; $display("FAIL clean_counts got %h exp %h", {packets_rcvd, beats_rcvd}, {64'd3, 64'd12});
        end
        checks++;
        if ({data_errors, length_errors, stray_beats, busy, done} !== {32'd0, 32'd0, 16'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL clean_status got %h exp %h", {data_errors, length_errors, stray_beats, busy, done}, {32'd0, 32'd0, 16'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_len_zero();
        pulse_start(64'd2, 8'd0);
        send_run(0, 2, 4);
        idle();
        checks++;
        if ({packets_rcvd, length_errors, data_errors, done} !== {64'd2, 32'd0, 32'd0, 1'b1}) begin
            errors++; $display("FAIL len_zero got %h exp %h", {packets_rcvd, length_errors, data_errors, done}, {64'd2, 32'd0, 32'd0, 1'b1});
        end
    endtask

    task automatic test_short_pkt();
        pulse_start(64'd3, 8'd4);
        beat(8'd0, 1'b0); beat(8'd1, 1'b0); beat(8'd2, 1'b1);
        idle();
        checks++;
        if ({packets_rcvd, length_errors, done} !== {64'd1, 32'd1, 1'b0}) begin
            errors++; $display("FAIL short_first got %h exp %h", {packets_rcvd, length_errors, done}, {64'd1, 32'd1, 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            beat(8'(3 + i), (i % 4) == 3);
        end
        idle();
        checks++;
        if ({packets_rcvd, beats_rcvd, length_errors, data_errors, done} !== {64'd3, 64'd11, 32'd1, 32'd0, 1'b1}) begin
            errors++; $display("FAIL short_total got %h exp %h", {packets_rcvd, beats_rcvd, length_errors, data_errors, done}, {64'd3, 64'd11, 32'd1, 32'd0, 1'b1});
        end
    endtask

    task automatic test_data_err();
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        pulse_start(64'd2, 8'd4);
        for (int i = 0; i < 8; i++) begin
            d = {KW{8'(i)}};
            if (i == 5) d[8*17 +: 8] = 8'hAA;
            drive(d, {KW{1'b1}}, (i % 4) == 3);
        end
        idle();
        checks++;
        if ({data_errors, first_err_beat, beats_rcvd, length_errors} !== {32'd1, 64'd5, 64'd8, 32'd0}) begin
            errors++; $display("FAIL byte_err got %h exp %h", {data_errors, first_err_beat, beats_rcvd, length_errors}, {32'd1, 64'd5, 64'd8, 32'd0});
        end
        pulse_start(64'd1, 8'd4);
        for (int i = 0; i < 4; i++) begin
            k = {KW{1'b1}};
            if (i == 2) k[0] = 1'b0;
            drive({KW{8'(i)}}, k, i == 3);
        end
        idle();
        checks++;
        if ({data_errors, first_err_beat, done} !== {32'd1, 64'd2, 1'b1}) begin
            errors++; $display("FAIL keep_err got %h exp %h", {data_errors, first_err_beat, done}, {32'd1, 64'd2, 1'b1});
        end
    endtask

    task automatic test_drop();
        logic [31:0] exp_err;
        pulse_start(64'd2, 8'd4);
        beat(8'd0, 1'b0); beat(8'd1, 1'b0); beat(8'd2, 1'b0); beat(8'd4, 1'b1);
        beat(8'd5, 1'b0); beat(8'd6, 1'b0); beat(8'd7, 1'b0); beat(8'd8, 1'b1);
        idle();
`ifdef DATA_CHECKER_RESYNC_EN
        exp_err = 32'd1;
`else
        exp_err = 32'd5;
`endif
        checks++;
        if ({data_errors, first_err_beat, packets_rcvd, length_errors} !== {exp_err, 64'd3, 64'd2, 32'd0}) begin
            errors++; $display("FAIL drop_beat got %h exp %h", {data_errors, first_err_beat, packets_rcvd, length_errors}, {exp_err, 64'd3, 64'd2, 32'd0});
        end
    endtask

    task automatic test_restart();
        pulse_start(64'd5, 8'd4);
        send_run(0, 1, 4);
        beat(8'd4, 1'b0); beat(8'd5, 1'b0);
        pulse_start(64'd2, 8'd4);
        beat(8'd6, 1'b0); beat(8'd7, 1'b1);
        idle();
        checks++;
        if ({packets_rcvd, beats_rcvd, busy, done} !== {64'd2, 64'd8, 1'b1, 1'b0}) begin
            errors++; $display("FAIL restart_old got %h exp %h", {packets_rcvd, beats_rcvd, busy, done}, {64'd2, 64'd8, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({packets_rcvd, beats_rcvd, busy, done} !== {64'd0, 64'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL restart_clear got %h exp %h", {packets_rcvd, beats_rcvd, busy, done}, {64'd0, 64'd0, 1'b1, 1'b0});
        end
        send_run(0, 2, 4);
        idle();
        checks++;
        if ({packets_rcvd, beats_rcvd, data_errors, length_errors, busy, done} !== {64'd2, 64'd8, 32'd0, 32'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL restart_new got %h exp %h", {packets_rcvd, beats_rcvd, data_errors, length_errors, busy, done}, {64'd2, 64'd8, 32'd0, 32'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(64'd2, 8'd4);
        beat(8'd0, 1'b0); beat(8'd1, 1'b0);
        @(negedge clk);
        resetn = 1'b0; AXIS_RX_TVALID = 1'b0;
        @(negedge clk);
        checks++;
        if ({packets_rcvd, beats_rcvd, first_err_beat, busy, done, AXIS_RX_TREADY} !== {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000}) begin
            errors++; $display("FAIL mid_reset got %h exp %h", {packets_rcvd, beats_rcvd, first_err_beat, busy, done, AXIS_RX_TREADY}, {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000});
        end
        resetn = 1'b1;
        beat(8'd9, 1'b0); beat(8'd9, 1'b1);
        idle();
        checks++;
        if ({stray_beats, beats_rcvd, busy} !== {16'd2, 64'd0, 1'b0}) begin
            errors++; $display("FAIL idle_stray got %h exp %h", {stray_beats, beats_rcvd, busy}, {16'd2, 64'd0, 1'b0});
        end
        pulse_start(64'd1, 8'd4);
        send_run(0, 1, 4);
        idle();
        checks++;
        if ({packets_rcvd, data_errors, length_errors, done} !== {64'd1, 32'd0, 32'd0, 1'b1}) begin
            errors++; $display("FAIL post_reset_run got %h exp %h", {packets_rcvd, data_errors, length_errors, done}, {64'd1, 32'd0, 32'd0, 1'b1});
        end
        beat(8'd0, 1'b0);
        idle();
        checks++;
        if ({stray_beats, beats_rcvd} !== {16'd1, 64'd4}) begin
            errors++; $display("FAIL done_stray got %h exp %h", {stray_beats, beats_rcvd}, {16'd1, 64'd4});
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; packet_count = 64'd0; packet_length = 8'd0;
        AXIS_RX_TDATA = '0; AXIS_RX_TKEEP = '0; AXIS_RX_TVALID = 1'b0; AXIS_RX_TLAST = 1'b0;
        test_reset();
        test_clean();
        test_len_zero();
        test_short_pkt();
        test_data_err();
        test_drop();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
